// File: rtl/synth_pkg.sv
// synth_pkg
//   Shared types and constants for the synth receive-side blocks.
//   demod_state_t      : pwm_demod frame-tracking states
//   PWM_PERIOD_DEFAULT : default clocks per PWM frame
package synth_pkg;

    typedef enum logic [1:0] {
        DEMOD_IDLE,
        DEMOD_SYNC,
        DEMOD_MEASURE
    } demod_state_t;

    localparam int PWM_PERIOD_DEFAULT = 256;

endpackage

// File: rtl/pwm_sync_filter.sv
// pwm_sync_filter
//   Brings the asynchronous PWM stream into the clk domain and finds its rising edges.
//   Optional build macro: PWM_DEMOD_FILTER_EN adds a 3-tap majority filter after the
//   synchronizer.
//   The filter removes single-cycle glitches at the cost of one extra clock of latency.
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   pwm_i  in   raw asynchronous PWM stream
//   pwm_s  out  synchronized (and optionally filtered) PWM level
//   rise   out  high for one cycle on each 0->1 transition of pwm_s
module pwm_sync_filter (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic pwm_s,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic pwm_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_i;
            sync2 <= sync1;
        end
    end

`ifdef PWM_DEMOD_FILTER_EN
    logic tap1;
    logic tap2;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap1 <= 1'b0;
            tap2 <= 1'b0;
        end else begin
            tap1 <= sync2;
            tap2 <= tap1;
        end
    end

    // Two of three agreeing taps are needed to change level.
    // An isolated one-cycle pulse therefore never reaches the output.
    assign pwm_s = (sync2 & tap1) | (sync2 & tap2) | (tap1 & tap2);
`else
    assign pwm_s = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_s_d <= 1'b0;
        end else begin
            pwm_s_d <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_s_d;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod
//   Recovers the duty-cycle sample from a PWM stream. It locks to frame boundaries on
//   rising edges, counts high cycles over PERIOD clocks, and emits one sample per frame.
//   Optional build macro: PWM_DEMOD_FILTER_EN (majority glitch filter in pwm_sync_filter).
// Ports
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   en              in   demodulator enable
//   pwm_i           in   asynchronous PWM stream
//   sample_o        out  high-cycle count of the last complete frame (saturated)
//   sample_valid_o  out  one-cycle pulse when sample_o updates
//   locked_o        out  high while tracking frames
//   sync_err_o      out  one-cycle pulse on a rising edge that is not at a frame start
module pwm_demod
    import synth_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      pwm_i,
    output logic [$clog2(PERIOD)-1:0] sample_o,
    output logic                      sample_valid_o,
    output logic                      locked_o,
    output logic                      sync_err_o
);

    localparam int SAMPLE_W = $clog2(PERIOD);
    localparam int CNT_W    = SAMPLE_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    demod_state_t        state,    state_n;
    logic [CNT_W-1:0]    cnt,      cnt_n;
    logic [CNT_W-1:0]    acc,      acc_n;
    logic [SAMPLE_W-1:0] sample_q, sample_n;
    logic                valid_q,  valid_n;
    logic                err_q,    err_n;
    logic [CNT_W-1:0]    sum;
    logic                pwm_s;
    logic                rise;

    pwm_sync_filter u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_i (pwm_i),
        .pwm_s (pwm_s),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DEMOD_IDLE;
            cnt      <= '0;
            acc      <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            sample_q <= sample_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
        end
    end

    // The accumulator can reach PERIOD on an all-high frame.
    // The extra bit of acc lets the saturation step detect that case.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        sample_n = sample_q;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        sum      = acc + {{SAMPLE_W{1'b0}}, pwm_s};

        if (!en) begin
            state_n = DEMOD_IDLE;
            cnt_n   = '0;
            acc_n   = '0;
        end else begin
            case (state)
                DEMOD_IDLE: begin
                    cnt_n   = '0;
                    acc_n   = '0;
                    state_n = DEMOD_SYNC;
                end
                DEMOD_SYNC: begin
                    if (rise) begin
                        cnt_n   = CNT_ONE;
                        acc_n   = CNT_ONE;
                        state_n = DEMOD_MEASURE;
                    end
                end
                DEMOD_MEASURE: begin
                    // A rise at cnt == 0 is the expected frame start.
                    // Any other rise realigns the frame and drops the partial count.
                    if (rise && (cnt != '0)) begin
                        err_n = 1'b1;
                        cnt_n = CNT_ONE;
                        acc_n = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        sample_n = sum[SAMPLE_W] ? {SAMPLE_W{1'b1}} : sum[SAMPLE_W-1:0];
                        valid_n  = 1'b1;
                        cnt_n    = '0;
                        acc_n    = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                        acc_n = sum;
                    end
                end
                default: begin
                    state_n = DEMOD_IDLE;
                end
            endcase
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q & en;
    assign sync_err_o     = err_q & en;
    assign locked_o       = (state == DEMOD_MEASURE) & en;

endmodule
